// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the synchronous FIFO family.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Purpose: WIDTH x DEPTH storage, synchronous write, asynchronous read (distributed RAM).
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates wr_en.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ptr_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_dat,
    input  logic [ptr_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Purpose: parametrised single-clock FIFO with thresholds, sticky errors, flush and FWFT option.
// Latency: standard mode data 1 cycle after rd_en edge; FWFT head visible 1 cycle after write.
// Backpressure: writes dropped when full, reads dropped when empty; both flagged sticky.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = MODE_STD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [WIDTH-1:0]        buf_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        buf_out,
    output logic                    buf_empty,
    output logic                    buf_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [cnt_w(DEPTH)-1:0] fifo_counter,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    generate
        if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_size
            $fatal(1, "fifo_sync_param: WIDTH must be >=1 and DEPTH a power of two >=4");
        end
        if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_thr
            $fatal(1, "fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_dat;
    logic             wr_acc;
    logic             rd_acc;
    logic             flush;

    assign flush  = !rst_n || clr;
    assign wr_acc = wr_en && !buf_full;
    assign rd_acc = rd_en && !buf_empty;

    assign buf_empty    = (fifo_counter == '0);
    assign buf_full     = (fifo_counter == CNT_W'(DEPTH));
    assign almost_empty = (fifo_counter <= CNT_W'(AE_LEVEL));
    assign almost_full  = (fifo_counter >= CNT_W'(AF_LEVEL));

    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !flush),
        .wr_addr (wr_ptr),
        .wr_dat  (buf_in),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   fifo_counter <= fifo_counter + CNT_W'(1);
                2'b01:   fifo_counter <= fifo_counter - CNT_W'(1);
                default: fifo_counter <= fifo_counter;
            endcase
            if (wr_en && buf_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && buf_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // FWFT shows the head word directly; standard mode registers it on each accepted read.
    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign buf_out = buf_empty ? '0 : rd_dat;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (flush) begin
                    buf_out <= '0;
                end else if (rd_acc) begin
                    buf_out <= rd_dat;
                end
            end
        end
    endgenerate

endmodule
